// File: rtl/hdmi_i2c_pkg.sv
// Shared definitions for the HDMI I2C config-port emulator: FSM encoding and default address.
package hdmi_i2c_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h39;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrPtr,
        StWrData,
        StRdData,
        StRdAck
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a stability filter; output follows the line only after
// FILT_LEN consecutive samples disagree with it.
module i2c_line_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line_raw,
    output logic line_filt
);

    localparam int unsigned CntW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

    logic            sync1_q, sync2_q, filt_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_raw;
            sync2_q <= sync1_q;
            // Any sample matching the current output restarts the stability count.
            if (sync2_q != filt_q) begin
                if (cnt_q == CntW'(FILT_LEN - 1)) begin
                    filt_q <= sync2_q;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign line_filt = filt_q;

endmodule

// File: rtl/hdmi_i2c_target.sv
// I2C target with a byte register bank shared with an Avalon-MM slave; emulates the HDMI
// transmitter's I2C configuration port.
module hdmi_i2c_target
    import hdmi_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              wr_pulse
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic scl_f, sda_f, scl_p_q, sda_p_q;
    logic start_ev, stop_ev, scl_r, scl_fall;

    i2c_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              byte_done_q, byte_done_d;
    logic              ack_q, ack_d;
    logic [7:0]        rx_q, rx_d, tx_q, tx_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic              sda_oe_q, sda_oe_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic              i2c_we, av_we;
    logic [7:0]        bank_q [NREGS];
    logic              unused_wdata;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk      (clk),
        .reset    (reset),
        .line_raw (scl_in),
        .line_filt(scl_f)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk      (clk),
        .reset    (reset),
        .line_raw (sda_in),
        .line_filt(sda_f)
    );

    assign start_ev = scl_f & scl_p_q & sda_p_q & ~sda_f;
    assign stop_ev  = scl_f & scl_p_q & ~sda_p_q & sda_f;
    assign scl_r    = scl_f & ~scl_p_q;
    assign scl_fall = ~scl_f & scl_p_q;
    assign ptr_inc  = ptr_q + ADDR_W'(1);
    assign av_we    = chipselect & ~write_n;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        ack_d       = ack_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        wr_pulse_d  = 1'b0;
        i2c_we      = 1'b0;

        // Receive-side shifting; the ACK clock pulse itself is not a data bit.
        if (scl_r && !ack_q &&
            (state_q == StAddr || state_q == StWrPtr || state_q == StWrData)) begin
            rx_d      = {rx_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
        end

        if (stop_ev || start_ev) begin
            state_d     = stop_ev ? StIdle : StAddr;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            ack_d       = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (rx_q[7:1] == DEV_ADDR) begin
                            sda_oe_d = 1'b1;
                            state_d  = StAddrAck;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = StIdle;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!rx_q[0]) begin
                            sda_oe_d = 1'b0;
                            state_d  = StWrPtr;
                        end else begin
                            tx_d      = bank_q[ptr_q];
                            sda_oe_d  = ~bank_q[ptr_q][7];
                            bit_cnt_d = '0;
                            state_d   = StRdData;
                        end
                    end
                end
                StWrPtr: begin
                    if (scl_fall) begin
                        if (ack_q) begin
                            ack_d    = 1'b0;
                            sda_oe_d = 1'b0;
                            state_d  = StWrData;
                        end else if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            ptr_d       = rx_q[ADDR_W-1:0];
                            sda_oe_d    = 1'b1;
                            ack_d       = 1'b1;
                        end
                    end
                end
                StWrData: begin
                    if (scl_fall) begin
                        if (ack_q) begin
                            ack_d    = 1'b0;
                            sda_oe_d = 1'b0;
                        end else if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            i2c_we      = 1'b1;
                            wr_pulse_d  = 1'b1;
                            ptr_d       = ptr_inc;
                            sda_oe_d    = 1'b1;
                            ack_d       = 1'b1;
                        end
                    end
                end
                StRdData: begin
                    if (scl_r) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
                    end
                    if (scl_fall) begin
                        if (byte_done_q) begin
                            byte_done_d = 1'b0;
                            sda_oe_d    = 1'b0;
                            state_d     = StRdAck;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                StRdAck: begin
                    // Next byte is captured at ACK time so later bank writes cannot disturb it.
                    if (scl_r && !ack_q) begin
                        if (!sda_f) begin
                            ptr_d = ptr_inc;
                            tx_d  = bank_q[ptr_inc];
                            ack_d = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                    if (scl_fall && ack_q) begin
                        ack_d     = 1'b0;
                        sda_oe_d  = ~tx_q[7];
                        bit_cnt_d = '0;
                        state_d   = StRdData;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
            ack_q       <= 1'b0;
            rx_q        <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            wr_pulse_q  <= 1'b0;
            scl_p_q     <= 1'b1;
            sda_p_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            ack_q       <= ack_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            wr_pulse_q  <= wr_pulse_d;
            scl_p_q     <= scl_f;
            sda_p_q     <= sda_f;
        end
    end

    // Avalon write is applied last so it wins a same-cycle collision with I2C.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) bank_q[i] <= 8'h00;
        end else begin
            if (i2c_we) bank_q[ptr_q] <= rx_q;
            if (av_we)  bank_q[address] <= writedata[7:0];
        end
    end

    assign readdata     = {24'b0, bank_q[address]};
    assign sda_oe       = sda_oe_q;
    assign wr_pulse     = wr_pulse_q;
    assign unused_wdata = ^writedata[31:8];

endmodule

// File: tb/tb_hdmi_i2c_target.sv
// Scoreboard bench for hdmi_i2c_target: bit-banged I2C initiator plus Avalon accesses.
module tb_hdmi_i2c_target;
    import hdmi_i2c_pkg::*;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        scl_m = 1'b1, glitch = 1'b0, sda_m = 1'b1;
    logic        scl_in, sda_in, sda_oe, wr_pulse;

    assign scl_in = scl_m | glitch;
    assign sda_in = sda_m & ~sda_oe;

    hdmi_i2c_target dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .wr_pulse  (wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct { logic exp; string name; } sb_t;
    typedef struct { int idx; logic [7:0] data; } wr_t;
    sb_t sbq[$];
    wr_t wq[$];
    int  n_checks = 0;
    int  n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected sda_oe for every initiator SCL high phase.
    always @(posedge scl_m) begin
        if (sbq.size() == 0) begin
            n_checks++;
            $display("FAIL sb_empty: got sda_oe=%b with no expectation queued", sda_oe);
        end else begin
            sb_t e;
            e = sbq.pop_front();
            check(e.name, 32'(sda_oe), 32'(e.exp));
        end
    end

    always @(negedge clk) begin
        if (!reset && wr_pulse) begin
            if (wq.size() == 0) begin
                check("wr_pulse_unexpected", 32'(wr_pulse), 32'd0);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("wr_bank", 32'(dut.bank_q[w.idx]), 32'(w.data));
            end
        end
    end

    task automatic push(input logic e, input string name);
        sb_t s;
        s.exp = e;
        s.name = name;
        sbq.push_back(s);
    endtask

    task automatic push_wr(input int idx, input logic [7:0] d);
        wr_t w;
        w.idx = idx;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_q();
        push(1'b0, "rstart_scl");
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        push(1'b0, "stop_scl");
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic clock_bit(input logic b, input logic exp_oe, input string name,
                             input bit glitch_first);
        if (glitch_first) begin
            glitch = 1'b1;
            repeat (2) @(negedge clk);
            glitch = 1'b0;
            wait_q();
        end
        sda_m = b; wait_q();
        push(exp_oe, name);
        scl_m = 1'b1; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_exp, input int glitch_bit);
        for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b0, "wr_bit_released", glitch_bit == i);
        clock_bit(1'b1, ack_exp, "target_ack", 1'b0);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic nack);
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, ~exp[i], "rd_bit", 1'b0);
        clock_bit(nack, 1'b0, "initiator_ack_released", 1'b0);
    endtask

    task automatic av_write(input logic [3:0] idx, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = idx; writedata = {24'hABCDEF, d};
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic av_check(input logic [3:0] idx, input logic [7:0] exp, input string name);
        @(negedge clk);
        address = idx;
        #1 check(name, readdata, {24'b0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_sda_oe", 32'(sda_oe), 32'd0);
        check("reset_wr_pulse", 32'(wr_pulse), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(StIdle));
        check("reset_ptr", 32'(dut.ptr_q), 32'd0);
        av_check(4'd9, 8'h00, "reset_bank9");

        // 1: pointer write then two data bytes
        i2c_start();
        send_byte(8'h72, 1'b1, -1);
        send_byte(8'h02, 1'b1, -1);
        push_wr(2, 8'hA5); send_byte(8'hA5, 1'b1, -1);
        push_wr(3, 8'h5A); send_byte(8'h5A, 1'b1, -1);
        i2c_stop();
        check("t1_ptr", 32'(dut.ptr_q), 32'd4);
        av_check(4'd2, 8'hA5, "t1_bank2");
        av_check(4'd3, 8'h5A, "t1_bank3");

        // 2: repeated-start read; bank[5] overwritten while its byte is in flight
        av_write(4'd5, 8'h3C);
        av_write(4'd6, 8'h96);
        i2c_start();
        send_byte(8'h72, 1'b1, -1);
        send_byte(8'h05, 1'b1, -1);
        i2c_rstart();
        send_byte(8'h73, 1'b1, -1);
        fork
            read_byte(8'h3C, 1'b0);
            begin
                repeat (40) @(negedge clk);
                av_write(4'd5, 8'hFF);
            end
        join
        read_byte(8'h96, 1'b1);
        check("t2_state_idle", 32'(dut.state_q), 32'(StIdle));
        check("t2_ptr", 32'(dut.ptr_q), 32'd6);
        i2c_stop();
        av_check(4'd5, 8'hFF, "t2_bank5");

        // 3: wrong address is never acknowledged
        i2c_start();
        send_byte(8'h74, 1'b0, -1);
        i2c_stop();
        av_check(4'd2, 8'hA5, "t3_bank2");

        // 4: pointer wrap
        i2c_start();
        send_byte(8'h72, 1'b1, -1);
        send_byte(8'h0F, 1'b1, -1);
        push_wr(15, 8'h11); send_byte(8'h11, 1'b1, -1);
        push_wr(0, 8'h22);  send_byte(8'h22, 1'b1, -1);
        i2c_stop();
        check("t4_ptr", 32'(dut.ptr_q), 32'd1);
        av_check(4'd15, 8'h11, "t4_bank15");
        av_check(4'd0, 8'h22, "t4_bank0");

        // 5: short SCL glitch mid-byte
        i2c_start();
        send_byte(8'h72, 1'b1, -1);
        send_byte(8'h07, 1'b1, -1);
        push_wr(7, 8'hC3); send_byte(8'hC3, 1'b1, 4);
        i2c_stop();
        av_check(4'd7, 8'hC3, "t5_bank7");

        // 6: partial byte then STOP, then reset during an ACK
        i2c_start();
        send_byte(8'h72, 1'b1, -1);
        send_byte(8'h01, 1'b1, -1);
        clock_bit(1'b1, 1'b0, "partial_bit", 1'b0);
        clock_bit(1'b0, 1'b0, "partial_bit", 1'b0);
        clock_bit(1'b1, 1'b0, "partial_bit", 1'b0);
        clock_bit(1'b0, 1'b0, "partial_bit", 1'b0);
        i2c_stop();
        check("t6_no_write_pending", 32'(wq.size()), 32'd0);
        check("t6_state_idle", 32'(dut.state_q), 32'(StIdle));
        av_check(4'd1, 8'h00, "t6_bank1");
        i2c_start();
        send_byte(8'h72, 1'b1, -1);
        for (int i = 7; i >= 0; i--) clock_bit(1'(i == 0), 1'b0, "wr_bit_released", 1'b0);
        sda_m = 1'b1; wait_q();
        check("t6_ack_driven", 32'(sda_oe), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_sda_oe_after_reset", 32'(sda_oe), 32'd0);
        check("t6_state_after_reset", 32'(dut.state_q), 32'(StIdle));
        push(1'b0, "post_reset_scl");
        scl_m = 1'b1; wait_q();
        scl_m = 1'b0; wait_q();
        i2c_stop();
        check("t6_state_end", 32'(dut.state_q), 32'(StIdle));
        av_check(4'd2, 8'h00, "t6_bank2_cleared");

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        check("wr_drained", 32'(wq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
